// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the sync_ram access controller: FSM encodings and default widths.
// Used by ram_access_ctrl and, when RAM_INIT_EN is defined, by ram_init_seq.
package ram_access_ctrl_pkg;

   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_IDLE     = 3'd1,
      ST_RD_ISSUE = 3'd2,
      ST_RD_CAP   = 3'd3,
      ST_RSP      = 3'd4
   } ctrl_state_e;

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset clearing sweep: walks every RAM address once and flags completion.
// Only present when the RAM_INIT_EN macro is defined.
`ifdef RAM_INIT_EN
module ram_init_seq
   import ram_access_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  issue,
   output logic                  done
);

   logic [ADDR_WIDTH-1:0] cnt_r;
   logic                  done_r;

   assign issue = en & ~done_r;
   assign addr  = cnt_r;
   assign done  = done_r;

   // Address counter advances once per issued clearing write; done latches after the top address.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r  <= {ADDR_WIDTH{1'b0}};
         done_r <= 1'b0;
      end else if (issue) begin
         cnt_r <= cnt_r + ADDR_WIDTH'(1);
         if (&cnt_r) begin
            done_r <= 1'b1;
         end else begin
            done_r <= done_r;
         end
      end else begin
         cnt_r  <= cnt_r;
         done_r <= done_r;
      end
   end

endmodule
`endif

// File: rtl/ram_access_ctrl.sv
// Valid/ready request/response front end for sync_ram; RAM pins are driven from registers.
// Define RAM_INIT_EN to clear the whole RAM after every reset (busy high during the sweep).
module ram_access_ctrl
   import ram_access_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  ram_writeEn,
   output logic                  ram_read,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  busy
);

`ifdef RAM_INIT_EN
   localparam ctrl_state_e RESET_STATE = ST_INIT;
`else
   localparam ctrl_state_e RESET_STATE = ST_IDLE;
`endif

   ctrl_state_e           state_r;
   ctrl_state_e           state_s;
   logic                  req_ready_r;
   logic                  rsp_valid_r;
   logic [DATA_WIDTH-1:0] rsp_rdata_r;
   logic                  ram_write_en_r;
   logic                  ram_read_r;
   logic [ADDR_WIDTH-1:0] ram_addr_r;
   logic [DATA_WIDTH-1:0] ram_din_r;
   logic                  req_fire_s;
   logic                  rsp_fire_s;

   assign req_fire_s = req_valid & req_ready_r;
   assign rsp_fire_s = rsp_valid_r & rsp_ready;

`ifdef RAM_INIT_EN
   logic                  init_en_s;
   logic [ADDR_WIDTH-1:0] init_addr_s;
   logic                  init_issue_s;
   logic                  init_done_s;
   logic                  busy_r;

   assign init_en_s = (state_r == ST_INIT);

   ram_init_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_init_seq (
      .clk   (clk),
      .reset (reset),
      .en    (init_en_s),
      .addr  (init_addr_s),
      .issue (init_issue_s),
      .done  (init_done_s)
   );

   // busy mirrors the next state so it rises and falls with the clearing-write pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= (state_s == ST_INIT);
      end
   end

   assign busy = busy_r;
`else
   assign busy = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= RESET_STATE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; writes never leave IDLE so they can stream one per cycle
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_INIT: begin
`ifdef RAM_INIT_EN
            if (init_done_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_INIT;
            end
`else
            state_s = ST_IDLE;
`endif
         end
         ST_IDLE: begin
            if (req_fire_s && !req_write) begin
               state_s = ST_RD_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD_ISSUE: state_s = ST_RD_CAP;
         ST_RD_CAP:   state_s = ST_RSP;
         ST_RSP: begin
            if (rsp_fire_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RSP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Registered RAM pins and response path; strobes default low so they pulse for one cycle only
   always_ff @(posedge clk) begin
      if (reset) begin
         req_ready_r    <= 1'b0;
         rsp_valid_r    <= 1'b0;
         rsp_rdata_r    <= {DATA_WIDTH{1'b0}};
         ram_write_en_r <= 1'b0;
         ram_read_r     <= 1'b0;
         ram_addr_r     <= {ADDR_WIDTH{1'b0}};
         ram_din_r      <= {DATA_WIDTH{1'b0}};
      end else begin
         req_ready_r    <= (state_s == ST_IDLE);
         ram_write_en_r <= 1'b0;
         ram_read_r     <= 1'b0;
         case (state_r)
            ST_INIT: begin
`ifdef RAM_INIT_EN
               if (init_issue_s) begin
                  ram_write_en_r <= 1'b1;
                  ram_addr_r     <= init_addr_s;
                  ram_din_r      <= {DATA_WIDTH{1'b0}};
               end else begin
                  ram_write_en_r <= 1'b0;
               end
`else
               ram_write_en_r <= 1'b0;
`endif
            end
            ST_IDLE: begin
               if (req_fire_s) begin
                  ram_addr_r <= req_addr;
                  if (req_write) begin
                     ram_write_en_r <= 1'b1;
                     ram_din_r      <= req_wdata;
                  end else begin
                     ram_read_r <= 1'b1;
                  end
               end else begin
                  ram_addr_r <= ram_addr_r;
               end
            end
            ST_RD_CAP: begin
               rsp_rdata_r <= ram_dout;
               rsp_valid_r <= 1'b1;
            end
            ST_RSP: begin
               if (rsp_fire_s) begin
                  rsp_valid_r <= 1'b0;
               end else begin
                  rsp_valid_r <= rsp_valid_r;
               end
            end
            default: begin
               rsp_valid_r <= rsp_valid_r;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_rdata   = rsp_rdata_r;
   assign ram_writeEn = ram_write_en_r;
   assign ram_read    = ram_read_r;
   assign ram_addr    = ram_addr_r;
   assign ram_din     = ram_din_r;

endmodule
